pixel_unpacker: RTL
===================

// Module: pixel_unpacker
// PURPOSE
//  AXI4-Stream video receiver: the decoding end of the pixel packer's stream. Accepts 32-bit
//  words carrying densely packed 24-bit RGB pixels (4 pixels per 3 words), tuser=SOF, tlast=EOL.
//  Emits one registered pixel per handshake with x/y coordinates and framing flags; detects
//  SOF/EOL framing errors and resynchronises. Used for loopback checking and as a frame-sink front end.
// PARAMETERS
//  X_SIZE   640  pixels per line; must be a multiple of 4
//  Y_SIZE   480  lines per frame
//  WPL      X_SIZE*3/4 (localparam)  stream words per line (480 at default)
// PORTS
//  in_stream_aclk     in   1   single clock for all logic
//  periph_resetn      in   1   reset, synchronous, active-low
//  in_stream_tdata    in   32  packed pixel bytes
//  in_stream_tkeep    in   4   ignored (always 4'hF from packer)
//  in_stream_tuser    in   1   start of frame, on first word of frame
//  in_stream_tlast    in   1   end of line, on last word of line
//  in_stream_tvalid   in   1   word valid
//  in_stream_tready   out  1   word accepted when tvalid&tready
//  r, g, b            out  8 each  pixel colour
//  x                  out  10  pixel column
//  y                  out  9   pixel row
//  sof                out  1   x==0 && y==0 for this pixel
//  eol                out  1   x==X_SIZE-1 for this pixel
//  pix_valid          out  1   pixel outputs valid
//  pix_ready          in   1   downstream accepts pixel when pix_valid&pix_ready
//  sof_err            out  1   one-cycle pulse: tuser on word not at frame start
//  eol_err            out  1   one-cycle pulse: tlast mismatch vs word counter
// BEHAVIOUR
//  - Reset (periph_resetn=0 at clk edge): pix_valid=0, r/g/b/x/y=0, sof/eol=0, errs=0, tready=0
//    during reset; phase=0, wc=0, next x/y=0, hold register cleared. Reset mid-frame drops state.
//  - Byte order: tdata is a little-endian byte stream; each pixel is 3 consecutive bytes
//    {r,g,b} forming pixel[23:0] = {r,g,b} with b at the lowest byte address.
//  - Phase FSM (P0..P3), hold reg up to 3 bytes:
//    P0: accept word; pixel=w[23:0]; hold w[31:24]; ->P1
//    P1: accept word; pixel={w[15:0],hold[7:0]}; hold w[31:16]; ->P2
//    P2: accept word; pixel={w[7:0],hold[15:0]}; hold w[31:8]; ->P3
//    P3: no word; pixel=hold[23:0]; ->P0
//  - in_stream_tready = periph_resetn && phase!=P3 && (!pix_valid || pix_ready).
//  - Output register loads when (word accepted) or (phase==P3 && (!pix_valid||pix_ready));
//    pix_valid rises the cycle after load condition; latency word-accept -> pix_valid = 1 clk.
//    Outputs stable while pix_valid && !pix_ready. Full throughput: 4 pixels / 4 clk.
//  - x/y tagged at load from next-x/next-y counters; x wraps at X_SIZE-1 -> 0 and y+1;
//    y wraps at Y_SIZE-1 -> 0.
//  - wc counts accepted words 0..WPL-1, wraps to 0 after WPL-1.
//  - SOF: tuser=1 on accepted word: if not (phase==P0 && wc==0 && next x==0 && next y==0)
//    pulse sof_err; in all cases treat word as P0, wc=0, tag x=0,y=0 (resync). tuser=0 at
//    frame start is not an error.
//  - EOL: tlast=1 with wc!=WPL-1 (early): pulse eol_err; pixels completed by that word are
//    emitted; held residual bytes discarded; next word starts P0, wc=0, x=0, y+1 (wrap).
//    tlast=0 with wc==WPL-1 (missing): pulse eol_err; counters wrap normally.
//  - tuser and tlast on same word: SOF rule applies first, then EOL rule on wc=0.
//  - Error pulses are registered, asserted the cycle after the offending word is accepted.
// CONFIGURATION
//  FRAME_STATS_EN defined: adds outputs frame_count[15:0] (increments on each accepted
//    tuser word, wraps at 16'hFFFF) and err_count[15:0] (increments per sof_err/eol_err
//    pulse, +2 if both same cycle, saturates at 16'hFFFF); both reset to 0.
//  FRAME_STATS_EN undefined: ports and counters absent; all other behaviour identical.
// TESTING
//  1 Reset, stream full 640x480 frame, pix_ready=1 -> 307200 pixels, first pixel x=0 y=0
//    sof=1, last x=639 y=479 eol=1, no error pulses, RGB matches source pattern.
//  2 Words 32'h44332211, 32'h88776655, 32'hCCBBAA99 -> pixels 0x332211, 0x665544,
//    0x998877, 0xCCBBAA in order.
//  3 pix_ready toggled random 50% -> no pixel lost/duplicated; tready=0 whenever phase=P3
//    or output stalled.
//  4 tlast on word 100 of line 3 -> eol_err pulse; next pixel tagged x=0 y=4; later tlast on
//    word 479 of line 4 -> no error.
//  5 tuser on word 10 of line 0 -> sof_err pulse; next pixel x=0 y=0; (FRAME_STATS_EN)
//    frame_count=2, err_count=1.
//  6 Assert reset mid-line 200 -> pix_valid=0 next edge; new frame after release decodes clean.

Source files
------------

// File: rtl/pixel_unpacker.sv
// AXI4-Stream receiver unpacking 4 RGB888 pixels from every 3 words, with x/y tagging and
// SOF/EOL framing checks. Optional FRAME_STATS_EN adds frame_count/err_count outputs.
module pixel_unpacker #(
  parameter int unsigned X_SIZE = 640,
  parameter int unsigned Y_SIZE = 480
) (
  input  logic        in_stream_aclk,
  input  logic        periph_resetn,
  input  logic [31:0] in_stream_tdata,
  input  logic [3:0]  in_stream_tkeep,
  input  logic        in_stream_tuser,
  input  logic        in_stream_tlast,
  input  logic        in_stream_tvalid,
  output logic        in_stream_tready,
  output logic [7:0]  r,
  output logic [7:0]  g,
  output logic [7:0]  b,
  output logic [9:0]  x,
  output logic [8:0]  y,
  output logic        sof,
  output logic        eol,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic        sof_err,
  output logic        eol_err
`ifdef FRAME_STATS_EN
  ,
  output logic [15:0] frame_count,
  output logic [15:0] err_count
`endif
);

  localparam int unsigned WPL = X_SIZE * 3 / 4;
  localparam int unsigned WcW = $clog2(WPL);
  localparam logic [9:0]     XMax  = 10'(X_SIZE - 1);
  localparam logic [8:0]     YMax  = 9'(Y_SIZE - 1);
  localparam logic [WcW-1:0] WcMax = WcW'(WPL - 1);

  typedef enum logic [1:0] {StP0, StP1, StP2, StP3} phase_e;

  phase_e         phase_q;
  logic [23:0]    hold_q;
  logic [WcW-1:0] wc_q;
  logic [9:0]     nx_q;
  logic [8:0]     ny_q;
  logic           brk_q;  // early EOL seen on a P2 word: line break after the P3 pixel

  logic           out_free, accept, p3_load, load, sync;
  phase_e         ph_eff, ph_nx;
  logic [23:0]    pix, hold_nx;
  logic [9:0]     tag_x, x_adv;
  logic [8:0]     tag_y, y_adv, y_inc;
  logic [WcW-1:0] wc_eff;
  logic           last_wc, early, missing, sof_bad, cut;
  logic           unused_tkeep;

  assign unused_tkeep     = ^in_stream_tkeep;
  assign out_free         = !pix_valid || pix_ready;
  assign in_stream_tready = periph_resetn && (phase_q != StP3) && out_free;
  assign accept           = in_stream_tvalid && in_stream_tready;
  assign p3_load          = (phase_q == StP3) && out_free;
  assign load             = accept || p3_load;
  assign sync             = accept && in_stream_tuser;

  always_comb begin
    ph_eff  = sync ? StP0 : phase_q;
    pix     = hold_q;
    hold_nx = hold_q;
    ph_nx   = StP0;
    unique case (ph_eff)
      StP0: begin
        pix     = in_stream_tdata[23:0];
        hold_nx = {16'h0, in_stream_tdata[31:24]};
        ph_nx   = StP1;
      end
      StP1: begin
        pix     = {in_stream_tdata[15:0], hold_q[7:0]};
        hold_nx = {8'h0, in_stream_tdata[31:16]};
        ph_nx   = StP2;
      end
      StP2: begin
        pix     = {in_stream_tdata[7:0], hold_q[15:0]};
        hold_nx = in_stream_tdata[31:8];
        ph_nx   = StP3;
      end
      StP3: begin
        pix     = hold_q;
        hold_nx = hold_q;
        ph_nx   = StP0;
      end
    endcase

    tag_x = sync ? 10'd0 : nx_q;
    tag_y = sync ? 9'd0 : ny_q;
    y_inc = (tag_y == YMax) ? 9'd0 : tag_y + 9'd1;
    if (tag_x == XMax) begin
      x_adv = 10'd0;
      y_adv = y_inc;
    end else begin
      x_adv = tag_x + 10'd1;
      y_adv = tag_y;
    end

    wc_eff  = sync ? '0 : wc_q;
    last_wc = (wc_eff == WcMax);
    early   = accept && in_stream_tlast && !last_wc;
    missing = accept && !in_stream_tlast && last_wc;
    sof_bad = sync && !(phase_q == StP0 && wc_q == '0 && nx_q == 10'd0 && ny_q == 9'd0);
    // Line break now unless a complete pixel is still held (P2 word): then defer to P3.
    cut     = (early && ph_eff != StP2) || (p3_load && brk_q);
  end

`ifdef FRAME_STATS_EN
  logic [16:0] err_sum;
  assign err_sum = {1'b0, err_count} + {16'h0, sof_bad} + {16'h0, early || missing};
`endif

  always_ff @(posedge in_stream_aclk) begin
    if (!periph_resetn) begin
      phase_q   <= StP0;
      hold_q    <= '0;
      wc_q      <= '0;
      nx_q      <= '0;
      ny_q      <= '0;
      brk_q     <= 1'b0;
      {r, g, b} <= '0;
      x         <= '0;
      y         <= '0;
      sof       <= 1'b0;
      eol       <= 1'b0;
      pix_valid <= 1'b0;
      sof_err   <= 1'b0;
      eol_err   <= 1'b0;
`ifdef FRAME_STATS_EN
      frame_count <= '0;
      err_count   <= '0;
`endif
    end else begin
      if (accept) begin
        phase_q <= (early && ph_eff != StP2) ? StP0 : ph_nx;
        hold_q  <= hold_nx;
        brk_q   <= early && (ph_eff == StP2);
        wc_q    <= (in_stream_tlast || last_wc) ? '0 : wc_eff + 1'b1;
      end else if (p3_load) begin
        phase_q <= StP0;
        brk_q   <= 1'b0;
      end

      if (load) begin
        nx_q      <= x_adv;
        ny_q      <= y_adv;
        {r, g, b} <= pix;
        x         <= tag_x;
        y         <= tag_y;
        sof       <= (tag_x == 10'd0) && (tag_y == 9'd0);
        eol       <= (tag_x == XMax);
        pix_valid <= 1'b1;
      end else if (pix_ready) begin
        pix_valid <= 1'b0;
      end
      if (cut) begin
        nx_q <= 10'd0;
        ny_q <= y_inc;
      end

      sof_err <= sof_bad;
      eol_err <= early || missing;
`ifdef FRAME_STATS_EN
      if (sync) frame_count <= frame_count + 16'd1;
      err_count <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
`endif
    end
  end

endmodule
